// File: rtl/vga_timing_pkg.sv
// 640x480 VGA timing constants shared by the generator and the decoder,
// plus the state encoding of the sync decoder.
package vga_timing_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int H_TOTAL      = 800;

    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;
    localparam int V_TOTAL      = 525;

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACQUIRE,
        LOCKED
    } sync_state_e;

endpackage

// File: rtl/sync_edge.sv
// Strobe-qualified falling-edge detector for an active-low sync input.
// The previous sample resets to 1 so an idle line never reports an edge.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stb,
    input  logic i_sig,
    output logic o_fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = prev_q;
        if (i_stb) begin
            prev_d = i_sig;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_fall = i_stb & ~i_sig & prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers x/y from a VGA hs/vs pair, checks line and frame periods,
// and reports lock once enough clean frames have been seen.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE_P     = H_ACTIVE,
    parameter int H_SYNC_START_P = H_SYNC_START,
    parameter int H_TOTAL_P      = H_TOTAL,
    parameter int V_ACTIVE_P     = V_ACTIVE,
    parameter int V_SYNC_START_P = V_SYNC_START,
    parameter int V_TOTAL_P      = V_TOTAL,
    parameter int LOCK_FRAMES    = 2,
    parameter int TIMEOUT        = 1600
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_active,
    output logic        o_frame,
    output logic        o_locked,
    output logic        o_err,
    output logic [10:0] o_line_len
);

    localparam logic [9:0]  X_LAST = 10'(H_TOTAL_P - 1);
    localparam logic [9:0]  X_SYNC = 10'(H_SYNC_START_P);
    localparam logic [9:0]  X_ACT  = 10'(H_ACTIVE_P);
    localparam logic [9:0]  Y_LAST = 10'(V_TOTAL_P - 1);
    localparam logic [9:0]  Y_SYNC = 10'(V_SYNC_START_P);
    localparam logic [9:0]  Y_ACT  = 10'(V_ACTIVE_P);
    localparam logic [9:0]  N_LINE = 10'(V_TOTAL_P);
    localparam logic [10:0] N_PIX  = 11'(H_TOTAL_P);
    localparam logic [10:0] TO_M1  = 11'(TIMEOUT - 1);
    localparam logic [7:0]  N_LOCK = 8'(LOCK_FRAMES);

    logic hs_fall;
    logic vs_fall;

    sync_edge u_hs_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_stb  (i_pix_stb),
        .i_sig  (i_hs),
        .o_fall (hs_fall)
    );

    sync_edge u_vs_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_stb  (i_pix_stb),
        .i_sig  (i_vs),
        .o_fall (vs_fall)
    );

    sync_state_e state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] per_q, per_d;
    logic [10:0] len_q, len_d;
    logic [9:0]  lines_q, lines_d;
    logic [7:0]  good_q, good_d;
    logic        err_q, err_d;
    logic        frame_q, frame_d;
    logic        active_q, active_d;

    logic        x_wrap;
    logic        y_wrap;
    logic        x_roll;
    logic [10:0] per_inc;
    logic [7:0]  good_inc;
    logic        hs_bad;
    logic        vs_bad;
    logic        timeout;

    always_comb begin
        x_wrap   = (x_q == X_LAST);
        y_wrap   = (y_q == Y_LAST);
        x_roll   = i_pix_stb & ~hs_fall & x_wrap;
        per_inc  = (per_q == 11'h7FF) ? per_q : per_q + 11'd1;
        good_inc = good_q + 8'd1;
        // per_inc includes the strobe carrying the edge, so one line is H_TOTAL
        hs_bad   = hs_fall & (per_inc != N_PIX);
        vs_bad   = vs_fall & ((lines_q != N_LINE) | ~x_wrap);
        timeout  = i_pix_stb & ~hs_fall & (per_q == TO_M1);

        x_d      = x_q;
        y_d      = y_q;
        per_d    = per_q;
        len_d    = len_q;
        lines_d  = lines_q;
        state_d  = state_q;
        good_d   = good_q;
        err_d    = 1'b0;
        frame_d  = 1'b0;

        if (i_pix_stb) begin
            if (hs_fall) begin
                x_d   = X_SYNC;
                len_d = per_inc;
                per_d = 11'd0;
            end else begin
                x_d   = x_wrap ? 10'd0 : x_q + 10'd1;
                per_d = per_inc;
            end

            if (vs_fall) begin
                y_d     = Y_SYNC;
                lines_d = hs_fall ? 10'd1 : 10'd0;
            end else begin
                if (x_roll) begin
                    y_d = y_wrap ? 10'd0 : y_q + 10'd1;
                end
                if (hs_fall && lines_q != 10'h3FF) begin
                    lines_d = lines_q + 10'd1;
                end
            end
        end

        unique case (state_q)
            SEARCH: begin
                if (hs_fall) begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (hs_bad) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end else if (vs_fall) begin
                    state_d = ACQUIRE;
                    good_d  = 8'd0;
                end
            end
            ACQUIRE: begin
                if (hs_bad || vs_bad) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end else if (vs_fall) begin
                    good_d = good_inc;
                    if (good_inc >= N_LOCK) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (hs_bad || vs_bad) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        if (timeout) begin
            state_d = SEARCH;
            err_d   = (state_q != SEARCH);
        end

        frame_d  = (state_q == LOCKED) & x_roll & y_wrap & ~vs_fall;
        active_d = (state_d == LOCKED) & (x_d < X_ACT) & (y_d < Y_ACT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= SEARCH;
            x_q      <= '0;
            y_q      <= '0;
            per_q    <= '0;
            len_q    <= '0;
            lines_q  <= '0;
            good_q   <= '0;
            err_q    <= 1'b0;
            frame_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            per_q    <= per_d;
            len_q    <= len_d;
            lines_q  <= lines_d;
            good_q   <= good_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
            active_q <= active_d;
        end
    end

    assign o_x        = x_q;
    assign o_y        = y_q;
    assign o_active   = active_q;
    assign o_frame    = frame_q;
    assign o_locked   = (state_q == LOCKED);
    assign o_err      = err_q;
    assign o_line_len = len_q;

endmodule
